// File: rtl/button_seq_detect.sv
// Button-sequence lock front end: sync + debounce four buttons, collect a 4-press code, drive tone enables.
// Press reaches the FSM DEBOUNCE_CYCLES+3 edges after the raw change; presses during a tone are dropped.
module button_seq_detect #(
  parameter int          DEBOUNCE_CYCLES = 1_250_000,
  parameter int          TONE_CYCLES     = 12_500_000,
  parameter int          TIMEOUT_CYCLES  = 625_000_000,
  parameter logic [7:0]  SEQ             = 8'h8D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic       EN392,
  output logic       EN110,
  output logic [2:0] progress,
  output logic       busy
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TNW = (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
  localparam int TMW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PASS    = 2'd2,
    S_FAIL    = 2'd3
  } state_t;

  // ---------------------------------------------------------------
  // Synchroniser, debounce and press-edge detection
  // ---------------------------------------------------------------
  logic [3:0]     sync1_q, sync1_d;
  logic [3:0]     sync2_q, sync2_d;
  logic [3:0]     stable_q, stable_d;
  logic [3:0]     stable_prev_q, stable_prev_d;
  logic [3:0]     press_q, press_d;
  logic [DBW-1:0] cnt_q [4];
  logic [DBW-1:0] cnt_d [4];

  always_comb begin
    sync1_d       = btn;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    press_d       = stable_q & ~stable_prev_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      press_q       <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------------------------------------------------------
  // Press decode against the expected digit for the current position
  // ---------------------------------------------------------------
  logic       any_press;
  logic       multi_press;
  logic [1:0] press_idx;
  logic [1:0] exp_idx;
  logic       mismatch;
  logic [2:0] prog_q, prog_d;

  always_comb begin
    any_press   = |press_q;
    // Several buttons in one cycle count as a single, always-wrong press.
    multi_press = (press_q & (press_q - 4'd1)) != 4'd0;
    case (press_q)
      4'b0010: press_idx = 2'd1;
      4'b0100: press_idx = 2'd2;
      4'b1000: press_idx = 2'd3;
      default: press_idx = 2'd0;
    endcase
    case (prog_q)
      3'd0:    exp_idx = SEQ[7:6];
      3'd1:    exp_idx = SEQ[5:4];
      3'd2:    exp_idx = SEQ[3:2];
      default: exp_idx = SEQ[1:0];
    endcase
    mismatch = multi_press | (press_idx != exp_idx);
  end

  // ---------------------------------------------------------------
  // Entry FSM: state register / next-state / outputs
  // ---------------------------------------------------------------
  state_t         state_q, state_d;
  logic           err_q, err_d;
  logic [TMW-1:0] tmr_q, tmr_d;
  logic [TNW-1:0] tone_q, tone_d;
  logic           en392_q, en392_d;
  logic           en110_q, en110_d;
  logic           busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prog_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      tone_q  <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      tone_q  <= tone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    tone_d  = tone_q;
    case (state_q)
      S_IDLE: begin
        if (any_press) begin
          state_d = S_COLLECT;
          prog_d  = 3'd1;
          err_d   = mismatch;
          tmr_d   = '0;
        end
      end
      S_COLLECT: begin
        // A press in the expiry cycle takes precedence over the timeout.
        if (any_press) begin
          prog_d = prog_q + 3'd1;
          err_d  = err_q | mismatch;
          tmr_d  = '0;
          if (prog_q == 3'd3) begin
            state_d = (err_q | mismatch) ? S_FAIL : S_PASS;
            tone_d  = '0;
          end
        end else if (tmr_q == TMW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          prog_d  = '0;
          err_d   = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_PASS, S_FAIL: begin
        if (tone_q == TNW'(TONE_CYCLES - 1)) begin
          state_d = S_IDLE;
          prog_d  = '0;
          err_d   = 1'b0;
          tone_d  = '0;
          tmr_d   = '0;
        end else begin
          tone_d = tone_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        prog_d  = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Enables derive from the next state so they rise on the same edge as progress.
  always_comb begin
    en392_d = (state_d == S_PASS);
    en110_d = (state_d == S_FAIL);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en392_q <= 1'b0;
      en110_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      en392_q <= en392_d;
      en110_q <= en110_d;
      busy_q  <= busy_d;
    end
  end

  assign EN392    = en392_q;
  assign EN110    = en110_q;
  assign busy     = busy_q;
  assign progress = prog_q;

endmodule

// File: tb/tb_button_seq_detect.sv
// Directed bench for button_seq_detect with short debounce/tone/timeout parameters.
module tb_button_seq_detect;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       EN392;
  logic       EN110;
  logic [2:0] progress;
  logic       busy;

  int nvec;
  int nerr;
  int en392_tot;
  int en110_tot;
  int both_tot;

  button_seq_detect #(
    .DEBOUNCE_CYCLES(4),
    .TONE_CYCLES    (20),
    .TIMEOUT_CYCLES (100),
    .SEQ            (8'h8D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .EN392   (EN392),
    .EN110   (EN110),
    .progress(progress),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Per-cycle enable tallies, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (EN392 === 1'b1) en392_tot++;
    if (EN110 === 1'b1) en110_tot++;
    if (EN392 === 1'b1 && EN110 === 1'b1) both_tot++;
  end

  initial begin
    #(8 * 20000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Drive one clean press starting at a falling edge; samples progress just
  // before and just after the expected FSM update (7th/8th falling edge).
  task automatic do_press(input logic [3:0] b, input int gap,
                          output logic [2:0] pre_p, output logic [2:0] post_p,
                          output logic [1:0] pre_en, output logic [1:0] post_en);
    btn = b;
    repeat (7) @(negedge clk);
    pre_p  = progress;
    pre_en = {EN392, EN110};
    @(negedge clk);
    post_p  = progress;
    post_en = {EN392, EN110};
    repeat (2) @(negedge clk);
    btn = 4'b0000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn   = 4'b0000;
    repeat (3) @(negedge clk);
    nvec++; if (EN392 !== 1'b0) begin nerr++; $display("FAIL reset_en392: got %b expected 0", EN392); end
    nvec++; if (EN110 !== 1'b0) begin nerr++; $display("FAIL reset_en110: got %b expected 0", EN110); end
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL reset_progress: got %0d expected 0", progress); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_correct_code;
    logic [3:0] seq_b [4];
    logic [2:0] pp, qp;
    logic [1:0] pe, qe;
    int a392, a110;
    seq_b = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    a392 = en392_tot;
    a110 = en110_tot;
    for (int k = 0; k < 4; k++) begin
      do_press(seq_b[k], 10, pp, qp, pe, qe);
      nvec++; if (pp !== 3'(k)) begin nerr++; $display("FAIL correct_pre_prog%0d: got %0d expected %0d", k, pp, k); end
      nvec++; if (qp !== 3'(k + 1)) begin nerr++; $display("FAIL correct_post_prog%0d: got %0d expected %0d", k, qp, k + 1); end
      if (k == 3) begin
        nvec++; if (pe !== 2'b00) begin nerr++; $display("FAIL correct_en_before: got %b expected 00", pe); end
        nvec++; if (qe !== 2'b10) begin nerr++; $display("FAIL correct_en_rise: got %b expected 10", qe); end
      end else begin
        nvec++; if (qe !== 2'b00) begin nerr++; $display("FAIL correct_en_early%0d: got %b expected 00", k, qe); end
      end
    end
    repeat (15) @(negedge clk);
    nvec++; if (en392_tot - a392 !== 20) begin nerr++; $display("FAIL correct_en392_len: got %0d expected 20", en392_tot - a392); end
    nvec++; if (en110_tot - a110 !== 0) begin nerr++; $display("FAIL correct_en110_len: got %0d expected 0", en110_tot - a110); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL correct_busy_end: got %b expected 0", busy); end
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL correct_prog_end: got %0d expected 0", progress); end
  endtask

  task automatic test_late_mismatch;
    logic [3:0] seq_b [4];
    logic [2:0] pp, qp;
    logic [1:0] pe, qe;
    int a392, a110;
    seq_b = '{4'b0100, 4'b0010, 4'b1000, 4'b0010};
    a392 = en392_tot;
    a110 = en110_tot;
    for (int k = 0; k < 4; k++) begin
      do_press(seq_b[k], 10, pp, qp, pe, qe);
      if (k == 1) begin
        nvec++; if (qp !== 3'd2) begin nerr++; $display("FAIL late_prog2: got %0d expected 2", qp); end
        nvec++; if (qe !== 2'b00) begin nerr++; $display("FAIL late_no_abort: got %b expected 00", qe); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL late_busy: got %b expected 1", busy); end
      end
      if (k == 3) begin
        nvec++; if (qe !== 2'b01) begin nerr++; $display("FAIL late_en110_rise: got %b expected 01", qe); end
      end
    end
    repeat (15) @(negedge clk);
    nvec++; if (en110_tot - a110 !== 20) begin nerr++; $display("FAIL late_en110_len: got %0d expected 20", en110_tot - a110); end
    nvec++; if (en392_tot - a392 !== 0) begin nerr++; $display("FAIL late_en392_len: got %0d expected 0", en392_tot - a392); end
  endtask

  task automatic test_bounce;
    int a392, a110;
    a392 = en392_tot;
    a110 = en110_tot;
    for (int i = 0; i < 3; i++) begin
      btn = 4'b0001;
      repeat (2) @(negedge clk);
      btn = 4'b0000;
      repeat (2) @(negedge clk);
    end
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL bounce_no_early: got %0d expected 0", progress); end
    btn = 4'b0001;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
    nvec++; if (progress !== 3'd1) begin nerr++; $display("FAIL bounce_one_press: got %0d expected 1", progress); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL bounce_busy: got %b expected 1", busy); end
    btn = 4'b1000;
    repeat (3) @(negedge clk);
    btn = 4'b0000;
    repeat (15) @(negedge clk);
    nvec++; if (progress !== 3'd1) begin nerr++; $display("FAIL glitch_ignored: got %0d expected 1", progress); end
    repeat (80) @(negedge clk);
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL bounce_timeout_prog: got %0d expected 0", progress); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL bounce_timeout_busy: got %b expected 0", busy); end
    nvec++; if ((en392_tot - a392) + (en110_tot - a110) !== 0) begin nerr++; $display("FAIL bounce_no_enable: got %0d expected 0", (en392_tot - a392) + (en110_tot - a110)); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] seq_b [4];
    logic [2:0] pp, qp;
    logic [1:0] pe, qe;
    int a392, a110;
    seq_b = '{4'b0011, 4'b0001, 4'b1000, 4'b0010};
    a392 = en392_tot;
    a110 = en110_tot;
    for (int k = 0; k < 4; k++) begin
      do_press(seq_b[k], 10, pp, qp, pe, qe);
      if (k == 0) begin
        nvec++; if (qp !== 3'd1) begin nerr++; $display("FAIL simul_one_press: got %0d expected 1", qp); end
      end
      if (k == 3) begin
        nvec++; if (qp !== 3'd4) begin nerr++; $display("FAIL simul_prog4: got %0d expected 4", qp); end
        nvec++; if (qe !== 2'b01) begin nerr++; $display("FAIL simul_en110_rise: got %b expected 01", qe); end
      end
    end
    repeat (15) @(negedge clk);
    nvec++; if (en110_tot - a110 !== 20) begin nerr++; $display("FAIL simul_en110_len: got %0d expected 20", en110_tot - a110); end
    nvec++; if (en392_tot - a392 !== 0) begin nerr++; $display("FAIL simul_en392_len: got %0d expected 0", en392_tot - a392); end
  endtask

  task automatic test_timeout_discard;
    logic [3:0] seq_b [4];
    logic [2:0] pp, qp;
    logic [1:0] pe, qe;
    int a392, a110;
    seq_b = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    a392 = en392_tot;
    a110 = en110_tot;
    do_press(4'b0100, 10, pp, qp, pe, qe);
    do_press(4'b0001, 10, pp, qp, pe, qe);
    nvec++; if (qp !== 3'd2) begin nerr++; $display("FAIL timeout_prog2: got %0d expected 2", qp); end
    repeat (87) @(negedge clk);
    nvec++; if (progress !== 3'd2) begin nerr++; $display("FAIL timeout_not_yet: got %0d expected 2", progress); end
    @(negedge clk);
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL timeout_prog0: got %0d expected 0", progress); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    nvec++; if ((en392_tot - a392) + (en110_tot - a110) !== 0) begin nerr++; $display("FAIL timeout_no_enable: got %0d expected 0", (en392_tot - a392) + (en110_tot - a110)); end
    repeat (5) @(negedge clk);
    a392 = en392_tot;
    for (int k = 0; k < 4; k++) begin
      do_press(seq_b[k], (k == 3) ? 0 : 10, pp, qp, pe, qe);
    end
    nvec++; if (qe !== 2'b10) begin nerr++; $display("FAIL after_timeout_en392: got %b expected 10", qe); end
    do_press(4'b0100, 10, pp, qp, pe, qe);
    nvec++; if (qp !== 3'd4) begin nerr++; $display("FAIL discard_prog: got %0d expected 4", qp); end
    nvec++; if (qe !== 2'b10) begin nerr++; $display("FAIL discard_en: got %b expected 10", qe); end
    repeat (20) @(negedge clk);
    nvec++; if (en392_tot - a392 !== 20) begin nerr++; $display("FAIL discard_single_tone: got %0d expected 20", en392_tot - a392); end
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL discard_prog_end: got %0d expected 0", progress); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL discard_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_tone;
    logic [3:0] seq_b [4];
    logic [2:0] pp, qp;
    logic [1:0] pe, qe;
    int a392;
    seq_b = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    for (int k = 0; k < 4; k++) begin
      do_press(seq_b[k], (k == 3) ? 0 : 10, pp, qp, pe, qe);
    end
    nvec++; if (EN392 !== 1'b1) begin nerr++; $display("FAIL midtone_en392_on: got %b expected 1", EN392); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nvec++; if (EN392 !== 1'b0) begin nerr++; $display("FAIL midtone_en392_off: got %b expected 0", EN392); end
    nvec++; if (progress !== 3'd0) begin nerr++; $display("FAIL midtone_prog: got %0d expected 0", progress); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midtone_busy: got %b expected 0", busy); end
    a392 = en392_tot;
    repeat (30) @(negedge clk);
    nvec++; if (en392_tot - a392 !== 0) begin nerr++; $display("FAIL midtone_no_resume: got %0d expected 0", en392_tot - a392); end
    for (int k = 0; k < 4; k++) begin
      do_press(seq_b[k], 10, pp, qp, pe, qe);
    end
    nvec++; if (qp !== 3'd4) begin nerr++; $display("FAIL post_reset_prog: got %0d expected 4", qp); end
    repeat (15) @(negedge clk);
    nvec++; if (en392_tot - a392 !== 20) begin nerr++; $display("FAIL post_reset_tone: got %0d expected 20", en392_tot - a392); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    btn   = 4'b0000;
    @(negedge clk);
    test_reset;
    test_correct_code;
    test_late_mismatch;
    test_bounce;
    test_simultaneous;
    test_timeout_discard;
    test_reset_mid_tone;
    nvec++; if (both_tot !== 0) begin nerr++; $display("FAIL enables_exclusive: got %0d overlap cycles expected 0", both_tot); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/button_seq_detect.md
# button_seq_detect

Front-end stage of the button-sequence lock. Synchronises and debounces four raw push-buttons and collects presses into a four-entry code. Compares the code against a fixed sequence and drives the one-hot enables of the downstream tone generator:
- `EN392` on a correct code.
- `EN110` on a wrong code.

Each enable is held for a fixed tone duration, then the block re-arms.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_250_000 — consecutive cycles a synchronised button level must differ from its debounced state before it is accepted (10 ms at 125 MHz); ≥2.
- `TONE_CYCLES`, 12_500_000 — cycles an enable is held (0.1 s); ≥1.
- `TIMEOUT_CYCLES`, 625_000_000 — max idle cycles between presses of a partial entry (5 s); ≥1.
- `SEQ`, 8'h8D — expected code, 2-bit button indices; `SEQ[7:6]` is the first press, `SEQ[1:0]` the fourth (default btn2, btn0, btn3, btn1).

Ports:
- `clk` in 1 — 125 MHz system clock; all logic on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `btn` in 4 — raw, asynchronous, bouncy buttons; 1 = pressed.
- `EN392` out 1 — correct-code tone enable to the tone generator.
- `EN110` out 1 — wrong-code tone enable to the tone generator.
- `progress` out 3 — presses accepted in the current entry, 0–4.
- `busy` out 1 — high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** two-flop per bit, `btn` → `sync2`.
- **Debounce (per bit):**
  - Counter `cnt` and state `stable`.
  - If `sync2 != stable`: `cnt++`. When `cnt == DEBOUNCE_CYCLES-1`, `stable <= sync2` and `cnt <= 0`.
  - Else `cnt <= 0`. Any bounce back restarts the count.
- **Press event:** registered one-cycle pulse `press[i] = stable[i] & ~stable_d[i]`. Releases generate nothing.
- **Press decode:** if exactly one `press` bit is high, index = its position. If ≥2 bits are high in one cycle, that is one press that is always a mismatch.
- **FSM states:** IDLE, COLLECT, PASS, FAIL.
  - IDLE: a press sets `progress = 1` and `err = (idx != SEQ[7:6])`, then goes to COLLECT.
  - COLLECT: each press increments `progress` and ORs its mismatch into `err`.
    - On the 4th press: go to PASS if `err == 0`, else FAIL.
    - Mismatch is only revealed after all four presses; there is no early abort.
    - `tmr` counts cycles since the last accepted press. At `tmr == TIMEOUT_CYCLES-1` with no press that cycle, go to IDLE, clear `progress`/`err`, and assert no enable.
  - PASS / FAIL: `EN392` / `EN110` high, tone counter runs `TONE_CYCLES` cycles, then go to IDLE with `progress <= 0`. Presses arriving in PASS/FAIL are discarded, not queued.
- `progress` reads 4 during PASS/FAIL and 0 in IDLE.
- Outputs are registered. `EN392` and `EN110` are never high simultaneously.
- `busy` is high in COLLECT, PASS and FAIL.
- **Widths:** each counter is `$clog2` of its parameter. Counters saturate never; they are cleared on state exit.

## Timing
- **Reset** (`rst_n` low at an edge) clears, at that edge:
  - sync flops, `stable`, `stable_d`, and all counters;
  - state to IDLE, `progress = 0`;
  - `EN392 = EN110 = busy = 0`.
- Reset has priority over everything, mid-entry or mid-tone.
- A button held through reset is seen as a fresh press after the debounce time.
- **Press latency:** with a raw change first sampled at edge E0:
  - `stable` flips at edge E0+1+`DEBOUNCE_CYCLES`;
  - `press` is high in the cycle after edge E0+2+`DEBOUNCE_CYCLES`;
  - FSM/`progress` update at E0+3+`DEBOUNCE_CYCLES`.
- On the 4th press, `EN392`/`EN110` rise at that same edge E0+3+`DEBOUNCE_CYCLES`. They stay high exactly `TONE_CYCLES` cycles and fall together with `busy`.
- A press may be accepted in the first IDLE cycle after a tone ends.
- **Timeout:** `TIMEOUT_CYCLES` cycles after the last accepted press, `progress` returns to 0. A press in the expiry cycle wins over the timeout.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `TONE_CYCLES=20`, `TIMEOUT_CYCLES=100`, `SEQ=8'h8D`; 8 ns clock.
- **Clean correct code:** btn2, btn0, btn3, btn1 pressed as clean 10-cycle pulses, 20 cycles apart → `progress` steps 1..4. `EN392` rises 7 cycles after the 4th press edge and is high exactly 20 cycles. `EN110` stays 0. Then `busy=0`, `progress=0`.
- **Late mismatch:** btn2, btn1, btn3, btn1 → no enable after press 2. `EN110` is high 20 cycles after press 4; `EN392` stays 0.
- **Bounce filtering:** btn0 toggles every 2 cycles for 12 cycles, then held 10 cycles → exactly one press, `progress=1`. A 3-cycle glitch on btn3 → no press.
- **Simultaneous buttons:** btn0+btn1 rising in the same cycle, then three correct-position presses → counts as one press, ends in FAIL (`EN110` for 20 cycles).
- **Timeout and discard:**
  - Two presses, then 100 idle cycles → `progress=0`, `busy=0`, no enable. A full correct code afterwards yields `EN392`.
  - Presses during PASS are ignored: `progress` stays 4 and no second tone follows.
- **Reset mid-tone:** `rst_n` low for one cycle while `EN392=1` → `EN392=0`, `progress=0`, `busy=0` after that edge. The next full code behaves normally.
